if_stage: RTL and testbench

Instruction-fetch stage for the pipelined MIPS datapath that runs the SAD kernel. It sits directly upstream of decode. It owns the program counter and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register and handles stall, flush, branch/jump redirect and halt.

---
 rtl/if_stage_if.sv | 29 ++
 rtl/if_stage.sv | 65 ++++++
 tb/tb_if_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// if_stage_if: control inputs, instruction-memory port and IF/ID outputs of the fetch stage
interface if_stage_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ProgramCounter;
    logic [31:0] pcPlus4;
    logic [31:0] instructionID;
    logic [31:0] pcPlus4ID;
    logic        validID;
    logic        halted;
    logic        misaligned;
    logic [15:0] fetchCount;
    modport master (
        output stall, flush, branch_taken, branch_target, jump, jump_target, imem_rdata,
        input  imem_addr, ProgramCounter, pcPlus4, instructionID, pcPlus4ID,
               validID, halted, misaligned, fetchCount
    );
    modport slave (
        input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_rdata,
        output imem_addr, ProgramCounter, pcPlus4, instructionID, pcPlus4ID,
               validID, halted, misaligned, fetchCount
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC, IF/ID register, stall/flush, redirect and halt
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic       clk,
    input logic       rst,
    if_stage_if.slave bus
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, pc_plus4, raw_target, target;
    logic [31:0] instruction_id, pc_plus4_id;
    logic        valid_id, misaligned, redirect, load, bubble;
    logic [15:0] fetch_count;
    assign pc_plus4   = pc + 32'd4;
    assign redirect   = bus.jump | bus.branch_taken;
    assign raw_target = bus.jump ? bus.jump_target : bus.branch_target;
    assign target     = {raw_target[31:2], 2'b00};
    // stall only holds IF/ID; a halted stage keeps feeding bubbles when not stalled
    assign bubble     = bus.flush | redirect | (!bus.stall && state == HALTED);
    assign load       = !bus.flush && !redirect && !bus.stall && state == RUN;
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        state_nx = redirect ? RUN : (load && bus.imem_rdata == HALT_WORD) ? HALTED : state;
        pc_nx    = redirect ? target : (bus.stall || state == HALTED) ? pc : pc_plus4;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            instruction_id <= '0;
            pc_plus4_id    <= '0;
            valid_id       <= 1'b0;
            misaligned     <= 1'b0;
            fetch_count    <= '0;
        end else begin
            pc <= pc_nx;
            if (redirect && |raw_target[1:0]) misaligned <= 1'b1;
            if (bubble) begin
                instruction_id <= '0;
                pc_plus4_id    <= '0;
                valid_id       <= 1'b0;
            end else if (load) begin
                instruction_id <= bus.imem_rdata;
                pc_plus4_id    <= pc_plus4;
                valid_id       <= 1'b1;
                fetch_count    <= fetch_count + {15'd0, fetch_count != 16'hFFFF};
            end
        end
    end
    assign bus.imem_addr      = pc;
    assign bus.ProgramCounter = pc;
    assign bus.pcPlus4        = pc_plus4;
    assign bus.instructionID  = instruction_id;
    assign bus.pcPlus4ID      = pc_plus4_id;
    assign bus.validID        = valid_id;
    assign bus.halted         = state == HALTED;
    assign bus.misaligned     = misaligned;
    assign bus.fetchCount     = fetch_count;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a per-edge behavioural model
module tb_if_stage;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;
    bit          halt_en = 1'b0;
    logic [31:0] halt_addr = 32'h0;
    logic [31:0] m_pc, m_ins, m_p4;
    logic        m_v, m_halt, m_mis;
    logic [15:0] m_cnt;

    if_stage_if bus();
    if_stage dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = 32'h2008_0001 + (a >> 2) * 32'h0001_0001;
        if (w == HALT) w = 32'h0;
        return (halt_en && a == halt_addr) ? HALT : w;
    endfunction
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Drive one cycle of inputs, advance the model by the stated rules, then cross the edge.
    task automatic step(input logic r, input logic s, input logic f, input logic b,
                        input logic [31:0] bt, input logic j, input logic [31:0] jt);
        logic        redir;
        logic [31:0] tgt, w;
        rst = r; bus.stall = s; bus.flush = f;
        bus.branch_taken = b; bus.branch_target = bt; bus.jump = j; bus.jump_target = jt;
        redir = j | b;
        tgt = j ? jt : bt;
        w = mem_word(m_pc);
        if (r) begin
            m_pc = 32'h0; m_ins = 0; m_p4 = 0; m_v = 0; m_halt = 0; m_mis = 0; m_cnt = 0;
        end else begin
            if (redir && tgt[1:0] != 2'b00) m_mis = 1;
            if (f || redir) begin
                m_ins = 0; m_p4 = 0; m_v = 0;
            end else if (!s) begin
                if (m_halt) begin
                    m_ins = 0; m_p4 = 0; m_v = 0;
                end else begin
                    m_ins = w; m_p4 = m_pc + 4; m_v = 1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                end
            end
            if (redir) m_pc = tgt & ~32'd3;
            else if (!s && !m_halt) m_pc = m_pc + 4;
            if (redir) m_halt = 0;
            else if (!f && !s && m_v && m_ins == HALT) m_halt = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        step(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, 32'h44, 1, 32'h13);
        step(1, 0, 0, 0, 0, 1, 32'h3);
        checks++;
        if (bus.ProgramCounter !== 32'h0 || bus.instructionID !== 32'h0 || bus.pcPlus4ID !== 32'h0 ||
            bus.validID !== 1'b0 || bus.halted !== 1'b0 || bus.misaligned !== 1'b0 || bus.fetchCount !== 16'h0) begin
            failures++;
            $display("FAIL reset: pc=%h ins=%h p4id=%h v=%b h=%b mis=%b cnt=%h required all zero",
                     bus.ProgramCounter, bus.instructionID, bus.pcPlus4ID, bus.validID, bus.halted,
                     bus.misaligned, bus.fetchCount);
        end
        checks++;
        if (bus.pcPlus4 !== 32'h4 || bus.imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_comb: pcPlus4=%h imem_addr=%h required 4/0", bus.pcPlus4, bus.imem_addr);
        end
    endtask

    task automatic test_sequential;
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        checks++;
        if (bus.ProgramCounter !== 32'h4 || bus.instructionID !== 32'h2008_0001 || bus.validID !== 1'b1) begin
            failures++;
            $display("FAIL seq_first: pc=%h ins=%h v=%b required 4/20080001/1",
                     bus.ProgramCounter, bus.instructionID, bus.validID);
        end
        idle(2);
        checks++;
        if (bus.ProgramCounter !== 32'hC || bus.instructionID !== 32'h200A_0003 ||
            bus.pcPlus4ID !== 32'hC || bus.fetchCount !== 16'd3) begin
            failures++;
            $display("FAIL seq_third: pc=%h ins=%h p4id=%h cnt=%0d required c/200a0003/c/3",
                     bus.ProgramCounter, bus.instructionID, bus.pcPlus4ID, bus.fetchCount);
        end
    endtask

    task automatic test_stall;
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            checks++;
            if (bus.ProgramCounter !== 32'h8 || bus.instructionID !== 32'h2009_0002 || bus.fetchCount !== 16'd2) begin
                failures++;
                $display("FAIL stall_hold[%0d]: pc=%h ins=%h cnt=%0d required 8/20090002/2",
                         i, bus.ProgramCounter, bus.instructionID, bus.fetchCount);
            end
        end
        idle(1);
        checks++;
        if (bus.ProgramCounter !== 32'hC || bus.instructionID !== 32'h200A_0003 || bus.fetchCount !== 16'd3) begin
            failures++;
            $display("FAIL stall_release: pc=%h ins=%h cnt=%0d required c/200a0003/3",
                     bus.ProgramCounter, bus.instructionID, bus.fetchCount);
        end
    endtask

    task automatic test_branch_stall;
        step(0, 1, 0, 1, 32'h40, 0, 0);
        checks++;
        if (bus.ProgramCounter !== 32'h40 || bus.validID !== 1'b0 || bus.instructionID !== 32'h0) begin
            failures++;
            $display("FAIL branch_stall: pc=%h v=%b ins=%h required 40/0/0",
                     bus.ProgramCounter, bus.validID, bus.instructionID);
        end
        idle(1);
        checks++;
        if (bus.instructionID !== 32'h2018_0011 || bus.validID !== 1'b1 || bus.ProgramCounter !== 32'h44) begin
            failures++;
            $display("FAIL branch_target_word: ins=%h v=%b pc=%h required 20180011/1/44",
                     bus.instructionID, bus.validID, bus.ProgramCounter);
        end
    endtask

    task automatic test_jump_priority;
        step(0, 0, 0, 1, 32'h80, 1, 32'h103);
        checks++;
        if (bus.ProgramCounter !== 32'h100 || bus.misaligned !== 1'b1) begin
            failures++;
            $display("FAIL jump_priority: pc=%h mis=%b required 100/1", bus.ProgramCounter, bus.misaligned);
        end
        idle(3);
        step(0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (bus.misaligned !== 1'b1 || bus.validID !== 1'b0 || bus.ProgramCounter !== 32'h10C) begin
            failures++;
            $display("FAIL flush_stall_sticky: mis=%b v=%b pc=%h required 1/0/10c",
                     bus.misaligned, bus.validID, bus.ProgramCounter);
        end
    endtask

    task automatic test_wrap;
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        idle(1);
        checks++;
        if (bus.ProgramCounter !== 32'h0 || bus.pcPlus4ID !== 32'h0 || bus.instructionID !== mem_word(32'hFFFF_FFFC)) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h p4id=%h ins=%h required 0/0/%h",
                     bus.ProgramCounter, bus.pcPlus4ID, bus.instructionID, mem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_halt;
        halt_en = 1; halt_addr = 32'h10;
        step(1, 0, 0, 0, 0, 0, 0);
        idle(5);
        checks++;
        if (bus.instructionID !== HALT || bus.validID !== 1'b1 || bus.halted !== 1'b1 || bus.ProgramCounter !== 32'h14) begin
            failures++;
            $display("FAIL halt_fetch: ins=%h v=%b h=%b pc=%h required ffffffff/1/1/14",
                     bus.instructionID, bus.validID, bus.halted, bus.ProgramCounter);
        end
        idle(3);
        step(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.validID !== 1'b0 || bus.halted !== 1'b1 || bus.ProgramCounter !== 32'h14 || bus.fetchCount !== 16'd5) begin
            failures++;
            $display("FAIL halt_frozen: v=%b h=%b pc=%h cnt=%0d required 0/1/14/5",
                     bus.validID, bus.halted, bus.ProgramCounter, bus.fetchCount);
        end
        step(0, 0, 0, 1, 32'h0, 0, 0);
        checks++;
        if (bus.halted !== 1'b0 || bus.ProgramCounter !== 32'h0 || bus.validID !== 1'b0) begin
            failures++;
            $display("FAIL halt_resume: h=%b pc=%h v=%b required 0/0/0", bus.halted, bus.ProgramCounter, bus.validID);
        end
        idle(1);
        checks++;
        if (bus.instructionID !== 32'h2008_0001 || bus.validID !== 1'b1 || bus.ProgramCounter !== 32'h4) begin
            failures++;
            $display("FAIL halt_refetch: ins=%h v=%b pc=%h required 20080001/1/4",
                     bus.instructionID, bus.validID, bus.ProgramCounter);
        end
        halt_en = 0;
    endtask

    task automatic test_saturation_and_reset;
        step(1, 0, 0, 0, 0, 0, 0);
        idle(65540);
        checks++;
        if (bus.fetchCount !== 16'hFFFF) begin
            failures++;
            $display("FAIL count_saturate: cnt=%h required ffff", bus.fetchCount);
        end
        step(0, 0, 0, 0, 0, 1, 32'h201);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.ProgramCounter !== 32'h0 || bus.instructionID !== 32'h0 || bus.pcPlus4ID !== 32'h0 ||
            bus.validID !== 1'b0 || bus.halted !== 1'b0 || bus.misaligned !== 1'b0 || bus.fetchCount !== 16'h0) begin
            failures++;
            $display("FAIL reset_midrun: pc=%h ins=%h p4id=%h v=%b h=%b mis=%b cnt=%h required all zero",
                     bus.ProgramCounter, bus.instructionID, bus.pcPlus4ID, bus.validID, bus.halted,
                     bus.misaligned, bus.fetchCount);
        end
    endtask

    task automatic test_random;
        logic [31:0] bt, jt;
        halt_en = 1; halt_addr = 32'h20;
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bt = $urandom_range(0, 31) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            jt = $urandom_range(0, 31) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, bt, $urandom_range(0, 19) == 0, jt);
            checks++;
            if (bus.ProgramCounter !== m_pc || bus.imem_addr !== m_pc || bus.pcPlus4 !== m_pc + 32'd4) begin
                failures++;
                $display("FAIL rand_pc[%0d]: pc=%h addr=%h p4=%h required pc %h", i, bus.ProgramCounter,
                         bus.imem_addr, bus.pcPlus4, m_pc);
            end
            checks++;
            if (bus.instructionID !== m_ins || bus.pcPlus4ID !== m_p4 || bus.validID !== m_v) begin
                failures++;
                $display("FAIL rand_ifid[%0d]: ins=%h p4id=%h v=%b required %h/%h/%b", i, bus.instructionID,
                         bus.pcPlus4ID, bus.validID, m_ins, m_p4, m_v);
            end
            checks++;
            if (bus.halted !== m_halt || bus.misaligned !== m_mis || bus.fetchCount !== m_cnt) begin
                failures++;
                $display("FAIL rand_status[%0d]: h=%b mis=%b cnt=%0d required %b/%b/%0d", i, bus.halted,
                         bus.misaligned, bus.fetchCount, m_halt, m_mis, m_cnt);
            end
        end
        halt_en = 0;
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_stall;
        test_branch_stall;
        test_jump_priority;
        test_wrap;
        test_halt;
        test_saturation_and_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
